// File: rtl/memshare_ib_remap_loader_if.sv
// Bundle of the loader's stream, decoder and rank-side signals.
// The loader uses the slave view; whatever drives the stream and decoder uses master.
interface memshare_ib_remap_loader_if #(
    parameter int QUAN_SIZE        = 4,
    parameter int SHARE_GROUP_SIZE = 4,
    parameter int COL_SEL_WIDTH    = 1,
    parameter int WDATA_SIZE       = 4
);
    logic                                      load_start_i;
    logic                                      load_abort_i;
    logic                                      remap_valid_i;
    logic                                      remap_ready_o;
    logic [WDATA_SIZE*SHARE_GROUP_SIZE-1:0]    remap_data_i;
    logic [COL_SEL_WIDTH*SHARE_GROUP_SIZE-1:0] dec_colSel_vec_i;
    logic [QUAN_SIZE*SHARE_GROUP_SIZE-1:0]     dec_c2v_msg_vec_i;
    logic [COL_SEL_WIDTH*SHARE_GROUP_SIZE-1:0] memShare_colSel_vec_o;
    logic [QUAN_SIZE*SHARE_GROUP_SIZE-1:0]     c2v_msg_vec_o;
    logic [WDATA_SIZE*SHARE_GROUP_SIZE-1:0]    remap_dataIn_vec_o;
    logic                                      nRemap_en_o;
    logic                                      busy_o;
    logic                                      load_done_o;

    modport slave (
        input  load_start_i, load_abort_i, remap_valid_i, remap_data_i,
               dec_colSel_vec_i, dec_c2v_msg_vec_i,
        output remap_ready_o, memShare_colSel_vec_o, c2v_msg_vec_o,
               remap_dataIn_vec_o, nRemap_en_o, busy_o, load_done_o
    );

    modport master (
        output load_start_i, load_abort_i, remap_valid_i, remap_data_i,
               dec_colSel_vec_i, dec_c2v_msg_vec_i,
        input  remap_ready_o, memShare_colSel_vec_o, c2v_msg_vec_o,
               remap_dataIn_vec_o, nRemap_en_o, busy_o, load_done_o
    );
endinterface

// File: rtl/memshare_ib_remap_loader.sv
// Write-side loader for a memory-shared VN IB-RAM rank: turns a valid/ready
// stream of remap words into active-low write strobes, walking the shared
// {column select, c2v} address space and broadcasting it to every element.
// Outside a load the decoder's address vectors pass straight through.
module memshare_ib_remap_loader #(
    parameter int QUAN_SIZE        = 4,
    parameter int SHARE_GROUP_SIZE = 4,
    parameter int COL_SEL_WIDTH    = 1,
    parameter int WDATA_SIZE       = 4,
    parameter int LOAD_CYCLE       = 32
) (
    input  logic                          sys_clk,
    input  logic                          rst,
    memshare_ib_remap_loader_if.slave     bus
);
    localparam int ADDR_W = COL_SEL_WIDTH + QUAN_SIZE;
    localparam int WD_W   = WDATA_SIZE * SHARE_GROUP_SIZE;
    localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(LOAD_CYCLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                              state_q, state_d;
    logic [ADDR_W-1:0]                   cnt_q, cnt_d;
    logic [ADDR_W-1:0]                   waddr_q, waddr_d;
    logic [WD_W-1:0]                     wdata_q, wdata_d;
    logic                                nen_q, nen_d;
    logic                                busy_q, busy_d;
    logic                                done_q, done_d;
    logic                                ready;
    logic                                accept;
    logic [COL_SEL_WIDTH*SHARE_GROUP_SIZE-1:0] col_sel_mux;
    logic [QUAN_SIZE*SHARE_GROUP_SIZE-1:0]     c2v_mux;

    // Abort drops ready in the same cycle so a coincident beat is never taken.
    assign ready  = (state_q == ST_LOAD) && !bus.load_abort_i;
    assign accept = ready && bus.remap_valid_i;

    // Next-state logic: FSM, beat counter and the registered write strobe/data/address.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        nen_d   = 1'b1;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.load_start_i) begin
                    state_d = ST_LOAD;
                    busy_d  = 1'b1;
                end
            end
            ST_LOAD: begin
                if (bus.load_abort_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else if (accept) begin
                    wdata_d = bus.remap_data_i;
                    waddr_d = cnt_q;
                    nen_d   = 1'b0;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // All loader state; reset releases the strobe immediately without waiting for a clock.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            nen_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            nen_q   <= nen_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Address mux: the write address is held while busy or strobing (covers the final
    // strobe in DONE), otherwise the decoder drives the rank.
    always_comb begin
        if (busy_q || !nen_q) begin
            col_sel_mux = {SHARE_GROUP_SIZE{waddr_q[ADDR_W-1:QUAN_SIZE]}};
            c2v_mux     = {SHARE_GROUP_SIZE{waddr_q[QUAN_SIZE-1:0]}};
        end else begin
            col_sel_mux = bus.dec_colSel_vec_i;
            c2v_mux     = bus.dec_c2v_msg_vec_i;
        end
    end

    assign bus.remap_ready_o         = ready;
    assign bus.memShare_colSel_vec_o = col_sel_mux;
    assign bus.c2v_msg_vec_o         = c2v_mux;
    assign bus.remap_dataIn_vec_o    = wdata_q;
    assign bus.nRemap_en_o           = nen_q;
    assign bus.busy_o                = busy_q;
    assign bus.load_done_o           = done_q;
endmodule

// File: doc/memshare_ib_remap_loader.md
Name: memshare_ib_remap_loader

Overview:
- Write-side controller for a rank of memory-shared VN IB-RAM cells.
- Accepts a valid/ready stream of remap words and drives the rank's active-low remap write strobe and write data.
- Walks the shared map/remap address space, driven as {column select, c2v message}, broadcast to every element of the share group.
- Outside a load, passes the decoder's column select and c2v vectors straight through to the rank address inputs.

Parameters:
- QUAN_SIZE, 4, message quantisation width; the low address field per element.
- SHARE_GROUP_SIZE, 4, number of VN IB-RAM elements in the rank.
- COL_SEL_WIDTH, 1, column-select width per element; the high address field.
- WDATA_SIZE, 4, remap write data bits per element per beat.
- LOAD_CYCLE, 32, beats per full load; must be ≤ 2^(COL_SEL_WIDTH+QUAN_SIZE).

Ports:
- sys_clk  in  1  single clock domain.
- rst  in  1  asynchronous, active-high reset.
- load_start_i  in  1  one-cycle pulse that begins a load; sampled only in IDLE.
- load_abort_i  in  1  terminates a load in progress; returns to IDLE with no done pulse.
- remap_valid_i  in  1  stream valid.
- remap_ready_o  out  1  stream ready.
- remap_data_i  in  WDATA_SIZE*SHARE_GROUP_SIZE  remap word; element g occupies [(g+1)*WDATA_SIZE-1 : g*WDATA_SIZE].
- dec_colSel_vec_i  in  COL_SEL_WIDTH*SHARE_GROUP_SIZE  decode-phase column select.
- dec_c2v_msg_vec_i  in  QUAN_SIZE*SHARE_GROUP_SIZE  decode-phase c2v messages.
- memShare_colSel_vec_o  out  COL_SEL_WIDTH*SHARE_GROUP_SIZE  rank column select.
- c2v_msg_vec_o  out  QUAN_SIZE*SHARE_GROUP_SIZE  rank c2v/address low field.
- remap_dataIn_vec_o  out  WDATA_SIZE*SHARE_GROUP_SIZE  rank write data.
- nRemap_en_o  out  1  active-low write strobe to the rank.
- busy_o  out  1  high in LOAD and DONE.
- load_done_o  out  1  one-cycle completion pulse.

Behaviour:
- Reset values: state IDLE, beat counter 0, nRemap_en_o=1, remap_dataIn_vec_o=0, remap_ready_o=0, busy_o=0, load_done_o=0, write-address register 0.
- FSM states:
  - IDLE → LOAD on load_start_i.
  - LOAD → DONE on the accepted beat with counter==LOAD_CYCLE-1.
  - LOAD → IDLE on load_abort_i.
  - DONE → IDLE unconditionally after one cycle.
- remap_ready_o is combinational: high only in LOAD and not load_abort_i.
- A beat is accepted when remap_valid_i && remap_ready_o. On the accepted beat, registered on the next edge:
  - remap_dataIn_vec_o ← remap_data_i.
  - write-address register ← counter.
  - nRemap_en_o ← 0.
  - counter increments.
- In any cycle without an accepted beat, nRemap_en_o ← 1. Data and address registers hold their values.
- Latency: exactly 1 cycle from the accept edge to the strobe. Valid gaps produce strobe gaps; address and data never advance without a strobe.
- Address split: address A is COL_SEL_WIDTH+QUAN_SIZE bits wide. The high COL_SEL_WIDTH bits go to every colSel slice; the low QUAN_SIZE bits go to every c2v slice.
- Address mux, combinational: busy_o or nRemap_en_o==0 selects the write-address register. Otherwise the outputs equal dec_colSel_vec_i and dec_c2v_msg_vec_i. The final strobe, which occurs in DONE, therefore still sees the write address.
- load_done_o is high for exactly the DONE cycle. busy_o is registered and high in LOAD and DONE.
- Counter wraps to 0 on entry to DONE and on abort.
- load_start_i outside IDLE is ignored.
- Abort on the same cycle as a valid beat: the beat is not accepted (ready is low). A strobe already registered from the previous cycle still completes.
- rst mid-load: immediate return to reset values, strobe deasserted asynchronously, no done pulse.

Test Plan:
- Reset then idle:
  - Stimulus: rst pulse; dec_colSel_vec_i=4'b1010, dec_c2v_msg_vec_i=16'h3C5A.
  - Required: nRemap_en_o=1; outputs pass through as 4'b1010 / 16'h3C5A; busy_o=0.
- Full back-to-back load:
  - Stimulus: start, valid held high, data=beat index replicated in each nibble (beat 5 → 16'h5555).
  - Required: 32 consecutive strobes, each one cycle after its accept. Beat 17 presents colSel=4'b1111, c2v=16'h1111, data 16'h1111. load_done_o pulses at the cycle of strobe 32; then IDLE and pass-through.
- Bubbled load:
  - Stimulus: valid toggles 1,0,0,1.
  - Required: strobes only on cycles after accepted beats; address advances 0 → 1 only across the gap; remap_dataIn_vec_o holds during bubbles.
- Abort at beat 10:
  - Stimulus: load_abort_i with valid high.
  - Required: beat 10 is not written; strobe for beat 9 completes; no load_done_o.
  - Follow-up: a new start restarts at address 0.
- Start while busy:
  - Stimulus: load_start_i at beat 3.
  - Required: ignored; the load finishes after exactly 32 strobes.
- Async reset mid-load at beat 20:
  - Required: nRemap_en_o=1 immediately, busy_o=0, no done pulse; a subsequent load begins at address 0.
